// File: rtl/adc_scan_ctrl.sv
// Multi-channel scan sequencer for a start/end-of-conversion ADC (sc, eoc, oe).
// Define ADC_TIMEOUT_EN to add the eoc wait timeout and the sticky timeout_err flag.
module adc_scan_ctrl #(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int DATA_W  = 8,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              continuous,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              eoc,
    input  logic [DATA_W-1:0] adc_data,
    output logic              sc,
    output logic              oe,
    output logic [CH_W-1:0]   ch_sel,
    output logic [DATA_W-1:0] data_out,
    output logic [CH_W-1:0]   data_ch,
    output logic              data_valid,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    if (SETTLE < 1 || SETTLE > 15 || TIMEOUT < 1 || NUM_CH < 2 || NUM_CH > 16 ||
        CH_W != $clog2(NUM_CH)) begin : g_param_check
        $error("adc_scan_ctrl: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_WAIT,
        S_READ,
        S_NEXT
    } state_t;

    state_t            state, state_n;
    logic [NUM_CH-1:0] mask_q;
    logic [3:0]        settle_cnt;
    logic              done_set;
    logic              ch_load;
    logic [CH_W-1:0]   ch_n;
    logic [CH_W-1:0]   first_go;
    logic [CH_W-1:0]   first_q;
    logic [CH_W-1:0]   higher_ch;
    logic              has_higher;

`ifdef ADC_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] wait_cnt;
    logic             tmo_hit;
`endif

    // Descending scan so the last match wins: yields the lowest qualifying channel.
    always_comb begin
        first_go   = '0;
        first_q    = '0;
        higher_ch  = '0;
        has_higher = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) first_go = CH_W'(i);
            if (mask_q[i])  first_q  = CH_W'(i);
            if (mask_q[i] && i > int'(ch_sel)) begin
                higher_ch  = CH_W'(i);
                has_higher = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        state_n  = state;
        done_set = 1'b0;
        ch_load  = 1'b0;
        ch_n     = ch_sel;
`ifdef ADC_TIMEOUT_EN
        tmo_hit  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (go) begin
                    if (|ch_mask) begin
                        state_n = S_SETTLE;
                        ch_load = 1'b1;
                        ch_n    = first_go;
                    end else begin
                        done_set = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_cnt == 4'(SETTLE - 1)) state_n = S_START;
            end
            S_START: state_n = S_WAIT;
            S_WAIT: begin
                if (eoc) begin
                    state_n = S_READ;
                end
`ifdef ADC_TIMEOUT_EN
                else if (wait_cnt == TMO_W'(TIMEOUT - 1)) begin
                    state_n  = S_IDLE;
                    done_set = 1'b1;
                    tmo_hit  = 1'b1;
                end
`endif
            end
            S_READ: state_n = S_NEXT;
            S_NEXT: begin
                if (has_higher) begin
                    state_n = S_SETTLE;
                    ch_load = 1'b1;
                    ch_n    = higher_ch;
                end else if (continuous && go) begin
                    state_n = S_SETTLE;
                    ch_load = 1'b1;
                    ch_n    = first_q;
                end else begin
                    state_n  = S_IDLE;
                    done_set = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: registers update with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the latched mask is reset too, so no scan can ever start from X channels.
            mask_q     <= '0;
            ch_sel     <= '0;
            data_out   <= '0;
            data_ch    <= '0;
            settle_cnt <= '0;
            done       <= 1'b0;
        end else begin
            done <= done_set;
            if (state == S_IDLE && go) mask_q <= ch_mask;
            if (ch_load) ch_sel <= ch_n;
            if (state == S_READ) begin
                data_out <= adc_data;
                data_ch  <= ch_sel;
            end
            if (state == S_SETTLE && state_n == S_SETTLE) settle_cnt <= settle_cnt + 4'd1;
            else                                          settle_cnt <= '0;
        end
    end

`ifdef ADC_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_WAIT && state_n == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
            else                                      wait_cnt <= '0;
            if (state == S_IDLE && go) timeout_err <= 1'b0;
            else if (tmo_hit)          timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    // Strobes decode straight from the state so an async reset clears them at once.
    assign sc         = (state == S_START);
    assign oe         = (state == S_READ);
    assign data_valid = (state == S_NEXT);
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Self-checking bench for adc_scan_ctrl: ADC responder feeds a result scoreboard
// that is drained whenever data_valid pulses.
module tb_adc_scan_ctrl;

    localparam int NUM_CH  = 4;
    localparam int CH_W    = 2;
    localparam int DATA_W  = 8;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              go = 1'b0;
    logic              continuous = 1'b0;
    logic [NUM_CH-1:0] ch_mask = '0;
    logic              adc_eoc = 1'b0;
    logic              stray_eoc = 1'b0;
    logic              eoc;
    logic [DATA_W-1:0] adc_data = '0;
    logic              sc, oe, data_valid, busy, done, timeout_err;
    logic [CH_W-1:0]   ch_sel, data_ch;
    logic [DATA_W-1:0] data_out;

    assign eoc = adc_eoc | stray_eoc;

    adc_scan_ctrl #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .continuous(continuous), .ch_mask(ch_mask),
        .eoc(eoc), .adc_data(adc_data), .sc(sc), .oe(oe), .ch_sel(ch_sel),
        .data_out(data_out), .data_ch(data_ch), .data_valid(data_valid), .busy(busy),
        .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int sc_cnt = 0, oe_cnt = 0, dv_cnt = 0, done_cnt = 0;
    int cyc = 0, dv_cyc = 0, done_cyc = 0;
    int b_sc, b_oe, b_dv, b_done;
    logic overlap_seen = 1'b0;

    logic [CH_W-1:0]        exp_ch_q[$];
    logic [CH_W+DATA_W-1:0] sb_q[$];
    logic [CH_W+DATA_W-1:0] sb_exp;
    int                     adc_delay = 3;
    logic                   adc_en = 1'b1;
    logic [DATA_W-1:0]      next_data = 8'hA5;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic snapshot();
        b_sc = sc_cnt; b_oe = oe_cnt; b_dv = dv_cnt; b_done = done_cnt;
    endtask

    task automatic pulse_go();
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, found, 1);
        #1;
    endtask

    task automatic wait_sc(input string tag, input int budget);
        logic found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sc) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, found, 1);
    endtask

    // Output monitor: event counters and the scoreboard drain.
    always @(negedge clk) begin
        cyc++;
        if (sc) sc_cnt++;
        if (oe) oe_cnt++;
        if (sc && oe) overlap_seen = 1'b1;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (data_valid) begin
            dv_cnt++;
            dv_cyc = cyc;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_dv", 1, 0);
            end else begin
                sb_exp = sb_q.pop_front();
                check("sb_ch_data", {data_ch, data_out}, sb_exp);
            end
        end
    end

    // ADC model: answers each sc after adc_delay edges and holds eoc until oe.
    initial begin
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] d;
        logic              got_oe;
        forever begin
            @(negedge clk);
            if (sc && adc_en && reset) begin
                d = next_data;
                next_data = next_data + 8'h3C;
                if (exp_ch_q.size() == 0) begin
                    check("adc_unexpected_sc", 1, 0);
                end else begin
                    ch = exp_ch_q.pop_front();
                    check("sc_ch_sel", ch_sel, ch);
                    sb_q.push_back({ch, d});
                end
                repeat (adc_delay) @(posedge clk);
                #1 adc_eoc = 1'b1;
                adc_data = d;
                got_oe = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (oe) begin
                        got_oe = 1'b1;
                        break;
                    end
                end
                check("adc_oe_seen", got_oe, 1);
                @(posedge clk); #1 adc_eoc = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "bench watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {sc, oe, data_valid, done, busy, timeout_err, ch_sel, data_out, data_ch}, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single channel, eoc 3 cycles after sc
        ch_mask = 4'b0001; adc_delay = 3; next_data = 8'hA5;
        exp_ch_q.push_back(2'd0);
        snapshot();
        pulse_go();
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (sc) begin
                n = i;
                break;
            end
        end
        check("t1_sc_latency", n, SETTLE + 1);
        wait_done("t1_done_seen", 50);
        check("t1_sc_count", sc_cnt - b_sc, 1);
        check("t1_oe_count", oe_cnt - b_oe, 1);
        check("t1_dv_count", dv_cnt - b_dv, 1);
        check("t1_done_count", done_cnt - b_done, 1);
        check("t1_done_after_dv", done_cyc - dv_cyc, 1);
        check("t1_data_out", data_out, 8'hA5);
        check("t1_busy_low", busy, 0);

        // 2: sparse mask, eoc already high on WAIT entry
        ch_mask = 4'b1010; adc_delay = 0;
        exp_ch_q.push_back(2'd1);
        exp_ch_q.push_back(2'd3);
        snapshot();
        pulse_go();
        wait_done("t2_done_seen", 100);
        check("t2_sc_count", sc_cnt - b_sc, 2);
        check("t2_dv_count", dv_cnt - b_dv, 2);
        check("t2_done_count", done_cnt - b_done, 1);
        check("t2_data_ch", data_ch, 3);

        // 3: continuous mode, two passes, then go drops
        ch_mask = 4'b0011; adc_delay = 1; continuous = 1'b1;
        for (int p = 0; p < 2; p++) begin
            exp_ch_q.push_back(2'd0);
            exp_ch_q.push_back(2'd1);
        end
        snapshot();
        @(posedge clk); #1 go = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sc_cnt - b_sc == 3) begin
                n = 1;
                break;
            end
        end
        check("t3_third_sc_seen", n, 1);
        @(posedge clk); #1 go = 1'b0;
        wait_done("t3_done_seen", 100);
        continuous = 1'b0;
        check("t3_sc_count", sc_cnt - b_sc, 4);
        check("t3_dv_count", dv_cnt - b_dv, 4);
        check("t3_done_count", done_cnt - b_done, 1);
        check("t3_busy_low", busy, 0);

        // 4: zero mask, then stray eoc in IDLE
        ch_mask = 4'b0000;
        snapshot();
        pulse_go();
        wait_done("t4_done_seen", 5);
        @(posedge clk); #1 stray_eoc = 1'b1;
        @(posedge clk); #1 stray_eoc = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("t4_sc_oe_dv_quiet", (sc_cnt - b_sc) + (oe_cnt - b_oe) + (dv_cnt - b_dv), 0);
        check("t4_done_count", done_cnt - b_done, 1);
        check("t4_busy_low", busy, 0);

        // 5: eoc never answered
        adc_en = 1'b0; ch_mask = 4'b0001;
        snapshot();
        pulse_go();
        wait_sc("t5_sc_seen", 20);
`ifdef ADC_TIMEOUT_EN
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                break;
            end
        end
        check("t5_timeout_latency", n, TIMEOUT + 1);
        #1;
        check("t5_timeout_err_set", timeout_err, 1);
        check("t5_no_dv", dv_cnt - b_dv, 0);
        check("t5_busy_low", busy, 0);
        ch_mask = 4'b0000;
        pulse_go();
        check("t5_timeout_err_cleared", timeout_err, 0);
        wait_done("t5_zero_done_seen", 5);
        // Re-enter WAIT for the async reset test
        ch_mask = 4'b0001;
        pulse_go();
        wait_sc("t6_sc_seen", 20);
        repeat (2) @(negedge clk);
`else
        repeat (40) @(negedge clk);
        #1;
        check("t5_busy_held", busy, 1);
        check("t5_timeout_err_zero", timeout_err, 0);
        check("t5_no_dv", dv_cnt - b_dv, 0);
`endif

        // 6: async reset while in WAIT
        snapshot();
        check("t6_busy_before", busy, 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t6_async_outs", {sc, oe, data_valid, done, busy, timeout_err, ch_sel, data_out, data_ch}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("t6_no_done", done_cnt - b_done, 0);
        check("t6_no_dv", dv_cnt - b_dv, 0);
        check("t6_idle", busy, 0);

        check("sc_oe_overlap", overlap_seen, 0);
        check("sb_drained", sb_q.size(), 0);
        check("exp_ch_drained", exp_ch_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
